// File: rtl/pwm_dac_stream.sv
// Streaming PWM DAC: valid/ready sample FIFO, one pop per sample tick, free-running PWM output.
// Optional PWM_DAC_UNDERRUN_MIDSCALE_EN: an underrun loads midscale instead of holding the last sample.
module pwm_dac_stream #(
   parameter int WIDTH         = 8,
   parameter int SAMPLE_PERIOD = 10240,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic                                 s_valid,
   input  logic [WIDTH-1:0]                     s_data,
   output logic                                 s_ready,
   output logic                                 pwm_out,
   output logic                                 underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

   localparam int LW  = $clog2(FIFO_DEPTH + 1);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int SCW = $clog2(SAMPLE_PERIOD);

   localparam logic [WIDTH-1:0] PWM_MAX  = '1;
   localparam logic [SCW-1:0]   RELOAD   = SCW'(SAMPLE_PERIOD - 1);
   localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);
`ifdef PWM_DAC_UNDERRUN_MIDSCALE_EN
   localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [WIDTH-1:0] pwm_cnt_q,      pwm_cnt_d;
   logic [WIDTH-1:0] duty_active_q,  duty_active_d;
   logic [WIDTH-1:0] duty_pending_q, duty_pending_d;
   logic [SCW-1:0]   samp_cnt_q,     samp_cnt_d;
   logic [PW-1:0]    wr_ptr_q,       wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q,       rd_ptr_d;
   logic [LW-1:0]    level_q,        level_d;
   logic             pwm_out_q,      pwm_out_d;
   logic             underrun_q,     underrun_d;
   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];

   logic tick;
   logic fifo_empty;
   logic push;
   logic pop;

   // s_ready comes straight from the registered level, so a pop this clock cannot raise it until next clock.
   assign fifo_empty = (level_q == '0);
   assign s_ready    = (level_q != FULL_LVL);
   assign tick       = enable && (samp_cnt_q == '0);
   assign push       = s_valid && s_ready;
   assign pop        = tick && !fifo_empty;

   always_comb begin
      pwm_cnt_d      = pwm_cnt_q;
      duty_active_d  = duty_active_q;
      duty_pending_d = duty_pending_q;
      samp_cnt_d     = samp_cnt_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      level_d        = level_q;
      mem_d          = mem_q;
      pwm_out_d      = enable && (pwm_cnt_q < duty_active_q);
      underrun_d     = tick && fifo_empty;

      if (enable) begin
         pwm_cnt_d = pwm_cnt_q + WIDTH'(1);
         // New duty only at the period boundary so no PWM period is ever truncated.
         if (pwm_cnt_q == PWM_MAX)
            duty_active_d = duty_pending_q;
         samp_cnt_d = (samp_cnt_q == '0) ? RELOAD : samp_cnt_q - SCW'(1);
      end

      if (push) begin
         mem_d[wr_ptr_q] = s_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end

      if (pop) begin
         duty_pending_d = mem_q[rd_ptr_q];
         rd_ptr_d       = rd_ptr_q + PW'(1);
      end
`ifdef PWM_DAC_UNDERRUN_MIDSCALE_EN
      else if (tick)
         duty_pending_d = MIDSCALE;
`endif

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt_q      <= '0;
         duty_active_q  <= '0;
         duty_pending_q <= '0;
         samp_cnt_q     <= RELOAD;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         pwm_out_q      <= 1'b0;
         underrun_q     <= 1'b0;
         mem_q          <= '{default: '0};
      end else begin
         pwm_cnt_q      <= pwm_cnt_d;
         duty_active_q  <= duty_active_d;
         duty_pending_q <= duty_pending_d;
         samp_cnt_q     <= samp_cnt_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         pwm_out_q      <= pwm_out_d;
         underrun_q     <= underrun_d;
         mem_q          <= mem_d;
      end
   end

   assign pwm_out    = pwm_out_q;
   assign underrun   = underrun_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_pwm_dac_stream.sv
// Directed bench for pwm_dac_stream at WIDTH=4, SAMPLE_PERIOD=64, FIFO_DEPTH=4.
// Expected values are hand-derived from the enabled-clock count since reset release.
module tb_pwm_dac_stream;

   localparam int WIDTH         = 4;
   localparam int SAMPLE_PERIOD = 64;
   localparam int FIFO_DEPTH    = 4;
`ifdef PWM_DAC_UNDERRUN_MIDSCALE_EN
   localparam int HOLD_DUTY = 8;
`else
   localparam int HOLD_DUTY = 12;
`endif

   logic             clk;
   logic             reset;
   logic             enable;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_ready;
   logic             pwm_out;
   logic             underrun;
   logic [2:0]       fifo_level;

   int test_count;
   int fail_count;
   int e;
   int high_cnt;
   int ur_cnt;

   pwm_dac_stream #(
      .WIDTH(WIDTH),
      .SAMPLE_PERIOD(SAMPLE_PERIOD),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .pwm_out(pwm_out),
      .underrun(underrun),
      .fifo_level(fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge; e counts enabled rising edges.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         if (enable) e++;
         @(negedge clk);
      end
   endtask

   task automatic runTo(input int target);
      applyStimulus(target - e);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      assert (obs === exp)
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h (e=%0d)", tag, obs, exp, e);
      end
   endtask

   task automatic checkPeriod(input int duty, input string tag);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1);
         checkOutput(tag, 32'(pwm_out), (i < duty) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      test_count = 0;
      fail_count = 0;
      e          = 0;
      reset      = 1'b1;
      enable     = 1'b1;
      s_valid    = 1'b0;
      s_data     = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_pwm",      32'(pwm_out),    32'd0);
      checkOutput("rst_underrun", 32'(underrun),   32'd0);
      checkOutput("rst_ready",    32'(s_ready),    32'd1);
      checkOutput("rst_level",    32'(fifo_level), 32'd0);
      reset = 1'b0;
      e     = 0;

      // Fill the FIFO with 8, 0, 15, 7 and then hold 12 on the bus while full.
      s_valid = 1'b1;
      s_data  = 4'd8;
      applyStimulus(1);
      checkOutput("level_one", 32'(fifo_level), 32'd1);
      s_data = 4'd0;
      applyStimulus(1);
      s_data = 4'd15;
      applyStimulus(1);
      s_data = 4'd7;
      applyStimulus(1);
      checkOutput("full_level", 32'(fifo_level), 32'd4);
      checkOutput("full_ready", 32'(s_ready),    32'd0);
      s_data = 4'd12;
      runTo(63);
      checkOutput("full_hold_level", 32'(fifo_level), 32'd4);
      checkOutput("no_early_tick",   32'(underrun),   32'd0);
      applyStimulus(1);
      checkOutput("tick1_level",    32'(fifo_level), 32'd3);
      checkOutput("tick1_ready",    32'(s_ready),    32'd1);
      checkOutput("tick1_underrun", 32'(underrun),   32'd0);
      applyStimulus(1);
      checkOutput("fifth_level", 32'(fifo_level), 32'd4);
      checkOutput("fifth_ready", 32'(s_ready),    32'd0);
      s_valid = 1'b0;

      runTo(80);
      checkOutput("pre_duty8", 32'(pwm_out), 32'd0);
      checkPeriod(8, "duty8");
      runTo(144);
      checkOutput("level_after_t2", 32'(fifo_level), 32'd3);
      checkPeriod(0, "duty0");
      runTo(208);
      checkPeriod(15, "duty15");
      checkOutput("level_after_t3", 32'(fifo_level), 32'd2);

      runTo(383);
      checkOutput("drained_level", 32'(fifo_level), 32'd0);
      checkOutput("pre_underrun",  32'(underrun),   32'd0);
      applyStimulus(1);
      checkOutput("underrun_pulse", 32'(underrun), 32'd1);
      applyStimulus(1);
      checkOutput("underrun_once", 32'(underrun), 32'd0);
      runTo(400);
      checkPeriod(HOLD_DUTY, "duty_hold");

      // Push on the very clock of an empty tick: no bypass, word waits for the next tick.
      runTo(447);
      s_valid = 1'b1;
      s_data  = 4'd5;
      applyStimulus(1);
      s_valid = 1'b0;
      checkOutput("tickpush_underrun", 32'(underrun),   32'd1);
      checkOutput("tickpush_level",    32'(fifo_level), 32'd1);
      runTo(511);
      checkOutput("tickpush_wait", 32'(fifo_level), 32'd1);
      applyStimulus(1);
      checkOutput("tickpush_pop",      32'(fifo_level), 32'd0);
      checkOutput("tickpush_no_under", 32'(underrun),   32'd0);
      runTo(528);
      checkPeriod(5, "duty5");

      runTo(548);
      checkOutput("pre_freeze_pwm", 32'(pwm_out), 32'd1);
      enable = 1'b0;
      applyStimulus(1);
      checkOutput("freeze_pwm_low", 32'(pwm_out), 32'd0);
      high_cnt = 0;
      ur_cnt   = 0;
      for (int i = 0; i < 99; i++) begin
         applyStimulus(1);
         if (pwm_out !== 1'b0) high_cnt++;
         if (underrun !== 1'b0) ur_cnt++;
      end
      checkOutput("freeze_pwm_highs",  32'(high_cnt), 32'd0);
      checkOutput("freeze_underruns",  32'(ur_cnt),   32'd0);
      enable = 1'b1;
      applyStimulus(1);
      checkOutput("resume_cnt4", 32'(pwm_out), 32'd1);
      applyStimulus(1);
      checkOutput("resume_cnt5", 32'(pwm_out), 32'd0);
      runTo(575);
      checkOutput("resume_no_tick", 32'(underrun), 32'd0);
      applyStimulus(1);
      checkOutput("resume_tick", 32'(underrun), 32'd1);

      s_valid = 1'b1;
      s_data  = 4'd9;
      applyStimulus(1);
      s_valid = 1'b0;
      checkOutput("prereset_level", 32'(fifo_level), 32'd1);
      runTo(580);
      checkOutput("prereset_pwm", 32'(pwm_out), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_pwm",      32'(pwm_out),    32'd0);
      checkOutput("async_level",    32'(fifo_level), 32'd0);
      checkOutput("async_ready",    32'(s_ready),    32'd1);
      checkOutput("async_underrun", 32'(underrun),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      e     = 0;
      runTo(63);
      checkOutput("post_reset_no_tick", 32'(underrun), 32'd0);
      applyStimulus(1);
      checkOutput("post_reset_tick", 32'(underrun), 32'd1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
